calc_alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle 8-bit calculator ALU between two requesters, for example two keypad control FSMs.
- It grants one request at a time and captures that request's operands and opcode.
- It issues a start pulse to the ALU and waits for the ALU's done, with a timeout.
- It returns the result to the granted requester with a one-cycle ready pulse.

The block sits between the control FSMs and the shared arithmetic datapath. The opcode is passed through opaquely.

---
 rtl/calc_alu_arbiter.sv | 131 +++++++++++++
 tb/tb_calc_alu_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_alu_arbiter.sv
// rtl/calc_alu_arbiter.sv - round-robin arbiter/sequencer sharing one multi-cycle ALU between two requesters
module calc_alu_arbiter #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] b0,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] b1,
    input  logic [2:0]    op0,
    input  logic [2:0]    op1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rdy0,
    output logic          rdy1,
    output logic [DW-1:0] res,
    output logic          err,
    output logic          busy,
    output logic          alu_start,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_done
);

    localparam int            TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            any_req;
    logic            win;
    logic            last;
    logic            owner;
    logic [TW-1:0]   timer;
    logic [DW-1:0]   hold_res;
    logic            hold_err;

    always_comb begin
        state_nxt = state;
        any_req   = req0 | req1;
        win       = (req0 && req1) ? ~last : req1;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (alu_done || timer == TIMER_LAST) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rdy0      <= 1'b0;
            rdy1      <= 1'b0;
            res       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            alu_start <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            last      <= 1'b1;
            owner     <= 1'b0;
            timer     <= '0;
            hold_res  <= '0;
            hold_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rdy0      <= 1'b0;
            rdy1      <= 1'b0;
            alu_start <= 1'b0;
            // busy stays up through the rdy cycle, which is already spent in IDLE
            busy      <= (state != S_IDLE) || (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt0   <= ~win;
                        gnt1   <= win;
                        last   <= win;
                        owner  <= win;
                        alu_a  <= win ? a1 : a0;
                        alu_b  <= win ? b1 : b0;
                        alu_op <= win ? op1 : op0;
                    end
                end
                S_ISSUE: begin
                    alu_start <= 1'b1;
                    timer     <= '0;
                end
                S_WAIT: begin
                    // alu_result is only valid with alu_done, so stage it until RESP
                    if (alu_done) begin
                        hold_res <= alu_result;
                        hold_err <= 1'b0;
                    end else if (timer == TIMER_LAST) begin
                        hold_res <= '0;
                        hold_err <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_RESP: begin
                    res  <= hold_res;
                    err  <= hold_err;
                    rdy0 <= ~owner;
                    rdy1 <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_alu_arbiter.sv
// tb/tb_calc_alu_arbiter.sv - scoreboard bench for calc_alu_arbiter
module tb_calc_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;
    logic       gnt0, gnt1, rdy0, rdy1, err, busy, alu_start;
    logic [7:0] res, alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_done;

    logic [7:0] alu_cnt;
    int         alu_k;
    bit         alu_en;
    logic       stray_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         who;
        logic [7:0] res;
        logic       err;
    } exp_t;
    exp_t exp_q[$];

    calc_alu_arbiter #(.DW(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .op0(op0), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .rdy0(rdy0), .rdy1(rdy1),
        .res(res), .err(err), .busy(busy),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_done(alu_done)
    );

    always #5 clk = ~clk;

    // ALU model: done strobes alu_k cycles after start is sampled
    always @(posedge clk) begin
        if (rst) alu_cnt <= 8'd0;
        else if (alu_start && alu_en) alu_cnt <= 8'(alu_k);
        else if (alu_cnt != 8'd0) alu_cnt <= alu_cnt - 8'd1;
    end
    assign alu_done = (alu_cnt == 8'd1) | stray_done;
    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pop the scoreboard on every rdy
    always @(negedge clk) begin
        if (gnt0 || gnt1) check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
        if (rdy0 || rdy1) begin
            check("rdy_exclusive", {31'd0, rdy0 & rdy1}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", {30'd0, rdy1, rdy0}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rdy_owner", {31'd0, rdy1}, {31'd0, e.who});
                check("res", {24'd0, res}, {24'd0, e.res});
                check("err", {31'd0, err}, {31'd0, e.err});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input bit who, input logic [7:0] r, input logic e);
        exp_t x;
        x.who = who; x.res = r; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
        check({tag, "_rdy"}, {30'd0, rdy1, rdy0}, 32'd0);
        check({tag, "_start"}, {31'd0, alu_start}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_res"}, {24'd0, res}, 32'd0);
        check({tag, "_alu_ops"}, {13'd0, alu_op, alu_a, alu_b}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    // hold requests until granted, then wait for the scoreboard to drain
    task automatic serve(input string tag, input int maxc);
        int n = 0;
        while ((req0 || req1 || exp_q.size() != 0) && n < maxc) begin
            tick();
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
            n++;
        end
        check({tag, "_drained"}, {31'd0, n >= maxc}, 32'd0);
        tick();
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  any_start;
        rst = 1'b1; req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; op0 = 0; op1 = 0;
        alu_k = 1; alu_en = 1; stray_done = 0;

        // reset and idle
        do_reset();
        any_start = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (alu_start || busy) any_start = 1;
        end
        check("idle_no_activity", {31'd0, any_start}, 32'd0);
        check_reset_outputs("reset");

        // single request, ALU done sampled at E3
        req0 = 1; a0 = 8'd4; b0 = 8'd3; op0 = 3'd0; alu_k = 1;
        push(0, 8'd7, 0);
        tick();
        check("single_gnt0_E0", {30'd0, gnt1, gnt0}, 32'd1);
        check("single_busy_E0", {31'd0, busy}, 32'd1);
        req0 = 0;
        tick();
        check("single_start_E1", {31'd0, alu_start}, 32'd1);
        check("single_alu_ab", {16'd0, alu_a, alu_b}, 32'h0403);
        tick(); tick();
        check("single_no_rdy_E3", {30'd0, rdy1, rdy0}, 32'd0);
        tick();
        check("single_rdy0_E4", {30'd0, rdy1, rdy0}, 32'd1);
        tick();
        check("single_busy_fall", {31'd0, busy}, 32'd0);

        // tie after reset: requester 0 first, then 1
        do_reset();
        req0 = 1; a0 = 8'd10; b0 = 8'd5; op0 = 3'd0;
        req1 = 1; a1 = 8'd20; b1 = 8'd6; op1 = 3'd1;
        push(0, 8'd15, 0);
        push(1, 8'd14, 0);
        tick();
        check("tie_first_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 0;
        serve("tie", 60);

        // repeated tie goes to requester 0 again
        req0 = 1; a0 = 8'd1; b0 = 8'd2; op0 = 3'd2;
        req1 = 1; a1 = 8'd7; b1 = 8'd7; op1 = 3'd0;
        push(0, 8'd3, 0);
        push(1, 8'd14, 0);
        tick();
        check("tie2_first_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 0;
        serve("tie2", 60);

        // timeout: rdy at E18
        alu_en = 0;
        req0 = 1; a0 = 8'd9; b0 = 8'd9; op0 = 3'd0;
        push(0, 8'd0, 1);
        tick();
        check("to_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 0;
        n = 0;
        while (!rdy0 && n < 40) begin
            tick();
            n++;
        end
        check("to_latency", n, 32'd18);
        tick();
        check("to_busy_fall", {31'd0, busy}, 32'd0);
        check("to_err_held", {31'd0, err}, 32'd1);
        alu_en = 1;

        // stray alu_done in IDLE
        stray_done = 1;
        tick();
        stray_done = 0;
        tick(); tick();
        check("stray_no_rdy", {30'd0, rdy1, rdy0}, 32'd0);
        check("stray_busy", {31'd0, busy}, 32'd0);
        check("stray_res_held", {23'd0, err, res}, 32'h100);

        // req1 arriving during WAIT waits for completion
        alu_k = 5;
        req0 = 1; a0 = 8'd2; b0 = 8'd2; op0 = 3'd0;
        push(0, 8'd4, 0);
        push(1, 8'd2, 0);
        tick();
        req0 = 0;
        tick(); tick();
        req1 = 1; a1 = 8'd3; b1 = 8'd1; op1 = 3'd1;
        seen = 0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (seen) begin
                check("late_gnt1_after_idle", {30'd0, gnt1, gnt0}, 32'd2);
                req1 = 0;
                break;
            end else if (rdy0) begin
                seen = 1;
            end else begin
                check("late_no_gnt1", {31'd0, gnt1}, 32'd0);
            end
        end
        check("late_rdy0_seen", {31'd0, seen}, 32'd1);
        alu_k = 1;
        serve("late", 60);

        // reset during WAIT
        alu_en = 0;
        req1 = 1; a1 = 8'd5; b1 = 8'd6; op1 = 3'd0;
        tick();
        check("mid_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
        req1 = 0;
        tick(); tick(); tick(); tick();
        rst = 1;
        tick();
        check_reset_outputs("midrst");
        rst = 0;
        tick(); tick(); tick();
        check("midrst_no_rdy", {30'd0, rdy1, rdy0}, 32'd0);
        alu_en = 1;
        req1 = 1;
        push(1, 8'd11, 0);
        serve("post_rst", 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
